// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with exact fill level, run-time programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a build-time choice of registered or FWFT read data.
module fifo_sync_prog #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4,
   parameter int FWFT     = 0
) (
   input  logic                CLK_I,
   input  logic                RST_I,
   input  logic                CLR_I,
   input  logic [DATASIZE-1:0] WDATA_I,
   input  logic                WINC_I,
   input  logic                RINC_I,
   input  logic [ADDRSIZE:0]   AFULL_TH_I,
   input  logic [ADDRSIZE:0]   AEMPTY_TH_I,
   output logic [DATASIZE-1:0] RDATA_O,
   output logic                WFULL_O,
   output logic                REMPTY_O,
   output logic                AFULL_O,
   output logic                AEMPTY_O,
   output logic [ADDRSIZE:0]   USEDW_O,
   output logic                OVF_O,
   output logic                UDF_O
);

   localparam int DEPTH = 2 ** ADDRSIZE;
   localparam logic [ADDRSIZE:0]   FULL_LVL = (ADDRSIZE + 1)'(DEPTH);
   localparam logic [ADDRSIZE:0]   LVL_ONE  = (ADDRSIZE + 1)'(1);
   localparam logic [ADDRSIZE-1:0] PTR_ONE  = ADDRSIZE'(1);

   logic [DATASIZE-1:0] mem_q [DEPTH];

   logic [ADDRSIZE-1:0] wptr_q, wptr_d;
   logic [ADDRSIZE-1:0] rptr_q, rptr_d;
   logic [ADDRSIZE:0]   level_q, level_d;
   logic                ovf_q, ovf_d;
   logic                udf_q, udf_d;

   logic full, empty, wr, rd, mem_we;

   // Flags decode straight from the registered level; thresholds act immediately.
   assign full     = (level_q == FULL_LVL);
   assign empty    = (level_q == '0);
   assign WFULL_O  = full;
   assign REMPTY_O = empty;
   assign AFULL_O  = (level_q >= AFULL_TH_I);
   assign AEMPTY_O = (level_q <= AEMPTY_TH_I);
   assign USEDW_O  = level_q;
   assign OVF_O    = ovf_q;
   assign UDF_O    = udf_q;

   // A request is accepted only against the current registered flags, so a
   // write into a full FIFO or a read from an empty one is simply dropped.
   assign wr     = WINC_I & ~full;
   assign rd     = RINC_I & ~empty;
   assign mem_we = wr & ~CLR_I & ~RST_I;

   // Next-state for pointers, level and sticky error flags; flush wins over requests.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (CLR_I) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else begin
         if (wr) wptr_d = wptr_q + PTR_ONE;
         if (rd) rptr_d = rptr_q + PTR_ONE;
         unique case ({wr, rd})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
         ovf_d = ovf_q | (WINC_I & full);
         udf_d = udf_q | (RINC_I & empty);
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge CLK_I) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples its pre-edge inputs regardless of statement order.
      if (RST_I) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage array write port.
   always_ff @(posedge CLK_I) begin
      // NOTE: the data array has no reset; the level counter alone decides
      // which entries are meaningful, and leaving it unreset lets it map to RAM.
      if (mem_we) mem_q[wptr_q] <= WDATA_I;
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [DATASIZE-1:0] rdata_q;

         // Registered read: load the head word on an accepted read, hold otherwise
         // (flush leaves it alone, reset clears it).
         always_ff @(posedge CLK_I) begin
            if (RST_I) begin
               rdata_q <= '0;
            end else if (rd & ~CLR_I) begin
               rdata_q <= mem_q[rptr_q];
            end
         end

         assign RDATA_O = rdata_q;
      end else begin : g_fwft_read
         // Head word is presented continuously; meaningless while empty.
         assign RDATA_O = mem_q[rptr_q];
      end
   endgenerate

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb_fifo_sync_prog: directed and scoreboard checks of fifo_sync_prog. Two
// instances share stimulus: one with registered read, one with FWFT.
module tb_fifo_sync_prog;

   logic       clk = 1'b0;
   logic       rst, clr, winc, rinc;
   logic [7:0] wdata;
   logic [4:0] afull_th, aempty_th;

   logic [7:0] rdata, f_rdata;
   logic       wfull, rempty, afull, aempty, ovf, udf;
   logic       f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_udf;
   logic [4:0] usedw, f_usedw;

   int total = 0;
   int bad   = 0;

   logic [7:0] q[$];
   logic [7:0] rdata_m = 8'h00;
   bit         ovf_m = 1'b0;
   bit         udf_m = 1'b0;

   always #5 clk = ~clk;

   fifo_sync_prog #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(0)) u_dut (
      .CLK_I(clk), .RST_I(rst), .CLR_I(clr), .WDATA_I(wdata),
      .WINC_I(winc), .RINC_I(rinc), .AFULL_TH_I(afull_th), .AEMPTY_TH_I(aempty_th),
      .RDATA_O(rdata), .WFULL_O(wfull), .REMPTY_O(rempty), .AFULL_O(afull),
      .AEMPTY_O(aempty), .USEDW_O(usedw), .OVF_O(ovf), .UDF_O(udf)
   );

   fifo_sync_prog #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(1)) u_fwft (
      .CLK_I(clk), .RST_I(rst), .CLR_I(clr), .WDATA_I(wdata),
      .WINC_I(winc), .RINC_I(rinc), .AFULL_TH_I(afull_th), .AEMPTY_TH_I(aempty_th),
      .RDATA_O(f_rdata), .WFULL_O(f_wfull), .REMPTY_O(f_rempty), .AFULL_O(f_afull),
      .AEMPTY_O(f_aempty), .USEDW_O(f_usedw), .OVF_O(f_ovf), .UDF_O(f_udf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given requests; the queue model is advanced from its
   // pre-edge state, and outputs are sampled 1 time unit after the edge.
   task automatic step(input logic w, input logic r, input logic [7:0] d,
                       input logic c, input logic s);
      bit full_m  = (q.size() == 16);
      bit empty_m = (q.size() == 0);
      winc = w; rinc = r; wdata = d; clr = c; rst = s;
      @(posedge clk);
      #1;
      if (s || c) begin
         q.delete();
         ovf_m = 1'b0;
         udf_m = 1'b0;
         if (s) rdata_m = 8'h00;
      end else begin
         if (r && !empty_m) rdata_m = q.pop_front();
         if (w && !full_m) q.push_back(d);
         if (w && full_m) ovf_m = 1'b1;
         if (r && empty_m) udf_m = 1'b1;
      end
      winc = 1'b0; rinc = 1'b0; clr = 1'b0; rst = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int n = q.size();
      check({tag, ".usedw"},  usedw,  n);
      check({tag, ".wfull"},  wfull,  n == 16);
      check({tag, ".rempty"}, rempty, n == 0);
      check({tag, ".afull"},  afull,  n >= int'(afull_th));
      check({tag, ".aempty"}, aempty, n <= int'(aempty_th));
      check({tag, ".ovf"},    ovf,    ovf_m);
      check({tag, ".udf"},    udf,    udf_m);
      check({tag, ".rdata"},  rdata,  rdata_m);
      check({tag, ".f_usedw"}, f_usedw, n);
      if (n > 0) check({tag, ".f_rdata"}, f_rdata, q[0]);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
      afull_th = 5'd12; aempty_th = 5'd2;

      // Reset state
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("rst.usedw", usedw, 0);
      check("rst.rempty", rempty, 1);
      check("rst.wfull", wfull, 0);
      check("rst.aempty", aempty, 1);
      check("rst.afull", afull, 0);
      check("rst.ovf", ovf, 0);
      check("rst.udf", udf, 0);
      check("rst.rdata", rdata, 8'h00);
      afull_th = 5'd0;
      #1;
      check("rst.afull_th0", afull, 1);
      afull_th = 5'd12;
      #1;

      // Fill with 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
         check("fill.usedw", usedw, i + 1);
         check("fill.afull", afull, (i + 1) >= 12);
         check("fill.wfull", wfull, (i + 1) == 16);
         check("fill.rempty", rempty, 0);
         if (i == 0) check("fill.fwft_first", f_rdata, 8'h00);
      end

      // Drain with registered read
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
         check("drain.rdata", rdata, i);
         check("drain.usedw", usedw, 15 - i);
      end
      check("drain.rempty", rempty, 1);
      check("drain.aempty", aempty, 1);
      check("drain.udf", udf, 0);

      // Refill 0x10..0x1F, then simultaneous write+read while full
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
      check("refill.wfull", wfull, 1);
      step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
      check("fullrw.usedw", usedw, 15);
      check("fullrw.ovf", ovf, 1);
      check("fullrw.rdata", rdata, 8'h10);
      check("fullrw.f_rdata", f_rdata, 8'h11);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check("fullrw.next", rdata, 8'h11);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check("fullrw.last", rdata, 8'h1F);
      check("fullrw.rempty", rempty, 1);
      check("fullrw.ovf_sticky", ovf, 1);

      // Read while empty, then flush, then FWFT write
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check("udf.udf", udf, 1);
      check("udf.usedw", usedw, 0);
      check("udf.rdata_hold", rdata, 8'h1F);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("clr.udf", udf, 0);
      check("clr.ovf", ovf, 0);
      check("clr.rdata_hold", rdata, 8'h1F);
      step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
      check("fwft.rdata", f_rdata, 8'hA5);
      check("fwft.rempty", f_rempty, 0);
      check("fwft.reg_rdata_hold", rdata, 8'h1F);

      // Empty with simultaneous write+read: write wins, underflow flagged
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
      check("emptyrw.usedw", usedw, 1);
      check("emptyrw.udf", udf, 1);
      check("emptyrw.f_rdata", f_rdata, 8'h3C);
      // Flush with requests in the same cycle: requests discarded
      step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
      check("clrreq.usedw", usedw, 0);
      check("clrreq.udf", udf, 0);
      check("clrreq.ovf", ovf, 0);
      check_all("clrreq");

      // Random concurrent traffic against the queue model
      for (int i = 0; i < 200; i++) begin
         logic w, r, c;
         w = ($urandom_range(0, 99) < ((i < 100) ? 70 : 40));
         r = ($urandom_range(0, 99) < ((i < 100) ? 40 : 70));
         c = ($urandom_range(0, 149) == 0);
         if (i % 50 == 25) begin
            afull_th  = 5'($urandom_range(0, 16));
            aempty_th = 5'($urandom_range(0, 16));
         end
         step(w, r, 8'($urandom), c, 1'b0);
         check_all("rand");
      end
      afull_th = 5'd12; aempty_th = 5'd2;

      // Reset at level 9 together with a write
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h49, 1'b0, 1'b0);
      check("lvl9.usedw", usedw, 9);
      check("lvl9.rdata", rdata, 8'h40);
      step(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
      check("mrst.usedw", usedw, 0);
      check("mrst.rempty", rempty, 1);
      check("mrst.wfull", wfull, 0);
      check("mrst.aempty", aempty, 1);
      check("mrst.afull", afull, 0);
      check("mrst.ovf", ovf, 0);
      check("mrst.udf", udf, 0);
      check("mrst.rdata", rdata, 8'h00);
      check("mrst.f_rempty", f_rempty, 1);

      // Normal operation resumes after reset
      step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check("post.rdata", rdata, 8'h5A);
      check_all("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
